// File: rtl/pending_enc_pkg.sv
// pending_enc_pkg: shared widths, state encoding and one-hot helper for the pending encoder.
package pending_enc_pkg;
  localparam int NUM_LINES = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;
  typedef enum logic {IDLE, HOLD} state_e;
  function automatic logic [NUM_LINES-1:0] onehot5(input logic [IDX_W-1:0] idx);
    return {{(NUM_LINES-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/priority_encoder_32to5.sv
// priority_encoder_32to5: rotating-start priority encoder; start=0 gives fixed priority.
module priority_encoder_32to5
  import pending_enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [NUM_LINES-1:0] vec,
  input  logic [IDX_W-1:0]     start,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);
  logic [NUM_LINES-1:0] rot;
  logic [IDX_W-1:0]     off;
  // rot[j] = vec[(j+start) mod 32]; the winner's offset is rotated back by adding start
  always_comb begin
    rot = NUM_LINES'({vec, vec} >> start);
    off = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (LSB_FIRST ? rot[NUM_LINES-1-i] : rot[i]) off = LSB_FIRST ? IDX_W'(NUM_LINES-1-i) : IDX_W'(i);
    end
    idx = off + start;
    any = |vec;
  end
endmodule

// File: rtl/pending_encoder_32to5.sv
// pending_encoder_32to5: accumulates request bits and drains them as 5-bit indices over valid/ready.
// Define PENDING_ENC_ROUND_ROBIN_EN for rotating priority instead of fixed priority.
module pending_encoder_32to5
  import pending_enc_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] set_vec,
  input  logic                 clear_all,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [IDX_W-1:0]     out_idx,
  output logic [CNT_W-1:0]     pend_count,
  output logic                 empty
);
  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] pend_q, pend_d, take_mask;
  logic [IDX_W-1:0]     idx_q, idx_d, enc_idx, start;
  logic                 any, load;
`ifdef PENDING_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_q;
  // reset value makes the first search begin where fixed priority would
  always_ff @(posedge clk) begin
    if (reset) last_q <= LSB_FIRST ? '1 : '0;
    else if (load) last_q <= enc_idx;
  end
  assign start = LSB_FIRST ? last_q + 1'b1 : last_q;
`else
  assign start = '0;
`endif
  priority_encoder_32to5 #(.LSB_FIRST(LSB_FIRST)) u_enc (
    .vec  (pend_q),
    .start(start),
    .idx  (enc_idx),
    .any  (any)
  );
  always_comb begin
    load      = !clear_all && any && (state_q == IDLE || out_ready);
    take_mask = load ? onehot5(enc_idx) : '0;
    pend_d    = clear_all ? '0 : (pend_q & ~take_mask) | set_vec;
    idx_d     = clear_all ? '0 : load ? enc_idx : idx_q;
    state_d   = clear_all ? IDLE : (load || (state_q == HOLD && !out_ready)) ? HOLD : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
    end
  end
  always_comb begin
    pend_count = '0;
    for (int i = 0; i < NUM_LINES; i++) pend_count = pend_count + CNT_W'(pend_q[i]);
  end
  assign out_valid = state_q == HOLD;
  assign out_idx   = idx_q;
  assign empty     = pend_q == '0 && state_q != HOLD;
endmodule

// File: tb/tb_pending_encoder_32to5.sv
// tb_pending_encoder_32to5: table vectors, corner sequences and random traffic against a reference model.
module tb_pending_encoder_32to5;
  localparam bit LSB = 1'b1;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] set_vec = '0;
  logic        clear_all = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic [5:0]  pend_count;
  logic        empty;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_pend = '0;
  bit          m_valid = 0;
  int          m_idx = 0;
  int          m_last = LSB ? 31 : 0;
  pending_encoder_32to5 #(.NUM_LINES(32), .LSB_FIRST(LSB)) dut (
    .clk(clk), .reset(reset), .set_vec(set_vec), .clear_all(clear_all), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .pend_count(pend_count), .empty(empty)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] s;
    logic c, r, v;
    logic [4:0] idx;
    logic [5:0] cnt;
    logic e;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int first_search();
`ifdef PENDING_ENC_ROUND_ROBIN_EN
    return LSB ? (m_last + 1) % 32 : (m_last + 31) % 32;
`else
    return LSB ? 0 : 31;
`endif
  endfunction
  // walk the 32 lines from the search origin in priority direction, take the first pending one
  function automatic int prio(input logic [31:0] p, input int org);
    for (int k = 0; k < 32; k++) begin
      int j;
      j = LSB ? (org + k) % 32 : (org - k + 32) % 32;
      if (p[j]) return j;
    end
    return 0;
  endfunction
  task automatic model_check();
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) chk("out_idx", {27'b0, out_idx}, m_idx);
    chk("pend_count", {26'b0, pend_count}, $countones(m_pend));
    chk("empty", {31'b0, empty}, {31'b0, m_pend == 0 && !m_valid});
  endtask
  task automatic tick(input logic [31:0] s, input logic c, input logic r);
    int nidx;
    bit ld;
    nidx = 0;
    set_vec = s;
    clear_all = c;
    out_ready = r;
    ld = !c && m_pend != 0 && (!m_valid || r);
    if (ld) begin
      nidx = prio(m_pend, first_search());
      m_idx = nidx;
      m_last = nidx;
    end
    m_pend = c ? 32'd0 : (m_pend & ~(ld ? (32'd1 << nidx) : 32'd0)) | s;
    m_valid = c ? 1'b0 : ld ? 1'b1 : (m_valid && !r);
    @(posedge clk);
    #1;
    model_check();
  endtask
  task automatic do_reset(input logic [31:0] s, input logic r);
    reset = 1'b1;
    set_vec = s;
    clear_all = 1'b0;
    out_ready = r;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pend = '0;
    m_valid = 0;
    m_idx = 0;
    m_last = LSB ? 31 : 0;
    model_check();
    chk("reset_idx", {27'b0, out_idx}, 32'd0);
  endtask
  function automatic void add(input logic [31:0] s, input logic c, input logic r, input logic v,
                              input logic [4:0] idx, input logic [5:0] cnt, input logic e);
    tbl.push_back('{s: s, c: c, r: r, v: v, idx: idx, cnt: cnt, e: e});
  endfunction
  initial begin
    for (int i = 0; i < 10; i++) add(32'h0, 0, 1, 0, 0, 0, 1);
    add(32'h8000_0011, 0, 1, 0, 0, 3, 0);
    add(32'h0, 0, 1, 1, 0, 2, 0);
    add(32'h0, 0, 1, 1, 4, 1, 0);
    add(32'h0, 0, 1, 1, 31, 0, 0);
    add(32'h0, 0, 1, 0, 0, 0, 1);
    add(32'h0000_0004, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(32'h0, 0, 0, 1, 2, 0, 0);
    add(32'h0, 0, 1, 0, 0, 0, 1);
    add(32'h0000_0008, 0, 0, 0, 0, 1, 0);
    add(32'h0, 0, 0, 1, 3, 0, 0);
    add(32'h0000_0008, 0, 1, 0, 0, 1, 0);
    add(32'h0, 0, 1, 1, 3, 0, 0);
    add(32'h0, 0, 1, 0, 0, 0, 1);
    add(32'hFFFF_FFFF, 0, 1, 0, 0, 32, 0);
    add(32'h0, 0, 1, 1, 0, 31, 0);
    add(32'h0, 0, 1, 1, 1, 30, 0);
    add(32'hFFFF_FFFF, 1, 1, 0, 0, 0, 1);
    add(32'h0, 0, 1, 0, 0, 0, 1);
    do_reset(32'h0, 1'b0);
    foreach (tbl[i]) begin
      tick(tbl[i].s, tbl[i].c, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].v});
      if (tbl[i].v) chk($sformatf("tbl%0d_idx", i), {27'b0, out_idx}, {27'b0, tbl[i].idx});
      chk($sformatf("tbl%0d_cnt", i), {26'b0, pend_count}, {26'b0, tbl[i].cnt});
      chk($sformatf("tbl%0d_empty", i), {31'b0, empty}, {31'b0, tbl[i].e});
    end
    tick(32'hFFFF_FFFF, 0, 1);
    for (int k = 0; k < 32; k++) begin
      tick(32'h0, 0, 1);
      chk("drain_idx", {27'b0, out_idx}, k);
    end
    tick(32'h0, 0, 1);
    chk("drain_empty", {31'b0, empty}, 32'd1);
    tick(32'h3, 0, 1);
    for (int k = 0; k < 6; k++) begin
      tick(32'h3, 0, 1);
`ifdef PENDING_ENC_ROUND_ROBIN_EN
      chk("rr_idx", {27'b0, out_idx}, k % 2);
`else
      chk("fixed_idx", {27'b0, out_idx}, 32'd0);
`endif
    end
    for (int k = 0; k < 4; k++) tick(32'h0, 0, 1);
    tick(32'h0000_0100, 0, 0);
    tick(32'h0, 0, 0);
    do_reset(32'h0000_0F00, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] s;
      s = ($urandom % 4 == 0) ? ($urandom & $urandom) : (($urandom % 8 == 0) ? 32'hFFFF_FFFF : 32'h0);
      if ($urandom % 500 == 0) do_reset(s, 1'($urandom));
      else tick(s, $urandom % 64 == 0, $urandom % 3 != 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
